ppi_sync_core: RTL and testbench
================================

// Module: ppi_sync_core
// PURPOSE
//  Synchronous, width-parametrised successor of the mode-0 PPI core.
//  Bus side: registered RD/WR access to port A, port B, port C and the control word.
//  Adds 8255-style mode 1 strobed handshake on ports A and B, and bit set/reset (BSR) on port C.
//  Sits between the CPU bus decoder and the pad-level tristate wrappers; pins are split into IN/OUT/OE.
// PARAMETERS
//  DW      8      width of each port and of DIN/DOUT; even, 8..64
//  CW      8      control word width; fixed at 8, low 8 bits of DIN
// PORTS
//  CLK        in   1      single clock, all logic rising-edge
//  RESET      in   1      synchronous, active-high
//  A          in   2      address: 00 PA, 01 PB, 10 PC, 11 control
//  RD         in   1      read strobe, one-cycle, active-high
//  WR         in   1      write strobe, one-cycle, active-high; RD&WR together = WR only
//  DIN        in   DW     write data
//  DOUT       out  DW     read data, registered
//  PA_IN/PB_IN/PC_IN    in   DW   pin sample
//  PA_OUT/PB_OUT/PC_OUT out  DW   output latch
//  PA_OE/PB_OE/PC_OE    out  DW   per-bit drive enable (all-1/all-0 per half for PC)
//  STB_A_N,STB_B_N in  1   mode-1 input strobe, active-low
//  ACK_A_N,ACK_B_N in  1   mode-1 output acknowledge, active-low
//  IBF_A,IBF_B    out  1   input buffer full
//  OBF_A_N,OBF_B_N out 1   output buffer full, active-low
//  INTR_A,INTR_B  out  1   interrupt request
// BEHAVIOUR
//  Reset: control=8'h9B (all ports mode-0 input); OUT latches 0; OE 0; DOUT 0; IBF 0; OBF_N 1; INTR 0; INTE 0.
//  Reset mid-handshake aborts it; no partial latch survives.
//  Read: DOUT updated the cycle after RD (1-cycle latency); DOUT holds between reads.
//  Read sources: mode-0 input = pin sample at RD cycle; output = OUT latch; mode-1 input = input latch.
//  Read PC: per half, pins if input, latch if output. Read A=11 returns the stored control word (zero-extended).
//  Write A=11, DIN[7]=1: mode set. Fields: [6:5] mode A (00=0, 01=1; 1x treated as 1), [4] A dir (1=in),
//   [3] PC upper dir, [2] mode B, [1] B dir, [0] PC lower dir. Mode set clears every OUT latch, IBF, INTR and INTE.
//   OBF_N returns to 1.
//  Write A=11, DIN[7]=0: BSR; index=DIN[6:1] (low clog2(DW) bits used); bit PC_OUT[index]=DIN[0]; index>=DW ignored.
//   Control word is unchanged. Index 0 writes INTE_A, index 1 writes INTE_B (in addition to PC bit).
//  Write to a port configured as input updates its OUT latch; the latch is not driven.
//  Mode 1 input (per port): STB_N sampled in flop; falling edge (1->0) latches pin into input latch and sets IBF.
//   Rising edge of STB_N with IBF=1 and INTE=1 sets INTR.
//   RD of that port clears IBF and INTR next cycle.
//   STB falling edge in the same cycle as RD: DOUT gets the old latch; IBF stays 1; new data latched.
//  Mode 1 output: WR of the port loads OUT and drives OBF_N=0 next cycle, clearing INTR.
//   Falling edge of ACK_N sets OBF_N=1. Rising edge of ACK_N sets INTR if INTE=1.
//   WR coinciding with ACK falling edge: new data loaded and OBF_N stays 0.
//  In mode 0, handshake outputs are held at reset values and STB/ACK are ignored.
// CONFIGURATION
//  PPI_INTR_EN defined: INTE flags and INTR_A/INTR_B logic as above.
//  PPI_INTR_EN undefined: no INTE flops; INTR_A=INTR_B=0; BSR indices 0/1 affect PC only.
// STRUCTURE
//  Package ppi_pkg holds:
//   - address localparams (ADDR_PA/PB/PC/CTRL)
//   - control-word bit positions
//   - reset control word 8'h9B
//   - typedef enum {MODE0, MODE1} ppi_mode_t
//  Sub-module ppi_hs_port: one per port A and B. Holds the edge detector, input/output latch,
//   IBF/OBF/INTR/INTE and direction/mode inputs. Top holds control word, PC, DOUT mux, decode.
// TESTING
//  1. Reset, then RD A=11 -> DOUT=8'h9B one cycle later; all OE=0, OBF_N=1, IBF=0.
//  2. WR ctrl 8'h80; WR PA 8'h5A -> PA_OE=FF, PA_OUT=5A; RD PA -> DOUT=5A.
//  3. WR ctrl 8'hB0 (A mode1 in), BSR 8'h01 (INTE_A); PA_IN=3C, pulse STB_A_N low 2 cycles
//     -> IBF_A=1, INTR_A=1 after STB rise; RD PA -> DOUT=3C, IBF_A=0, INTR_A=0.
//  4. WR ctrl 8'h84 (B mode1 out), BSR 8'h03; WR PB 8'hC3 -> OBF_B_N=0; pulse ACK_B_N
//     -> OBF_B_N=1 on fall, INTR_B=1 on rise; next WR PB clears INTR_B.
//  5. BSR 8'h0F then 8'h0E (index 7) with PC output -> PC_OUT[7] 1 then 0; control word unchanged.
//  6. STB_A falling edge in same cycle as RD PA -> DOUT=old data, IBF_A stays 1, then RD returns new data.

Source files
------------

// File: rtl/ppi_pkg.sv
// Shared constants and types for the synchronous PPI core: bus addresses,
// control-word field positions, reset control word and port mode type.
package ppi_pkg;

  localparam logic [1:0] ADDR_PA   = 2'b00;
  localparam logic [1:0] ADDR_PB   = 2'b01;
  localparam logic [1:0] ADDR_PC   = 2'b10;
  localparam logic [1:0] ADDR_CTRL = 2'b11;

  localparam int CW_MODE_SET = 7;
  localparam int CW_MODEA_HI = 6;
  localparam int CW_MODEA_LO = 5;
  localparam int CW_DIR_A    = 4;
  localparam int CW_DIR_PCU  = 3;
  localparam int CW_MODE_B   = 2;
  localparam int CW_DIR_B    = 1;
  localparam int CW_DIR_PCL  = 0;

  localparam logic [7:0] CTRL_RESET = 8'h9B;

  typedef enum logic {MODE0 = 1'b0, MODE1 = 1'b1} ppi_mode_t;

  // Group A modes 1x have no strobed/bidirectional distinction here; treat as mode 1.
  function automatic ppi_mode_t modeOfA(input logic [7:0] cw);
    return (cw[CW_MODEA_HI:CW_MODEA_LO] != 2'b00) ? MODE1 : MODE0;
  endfunction

  function automatic ppi_mode_t modeOfB(input logic [7:0] cw);
    return cw[CW_MODE_B] ? MODE1 : MODE0;
  endfunction

endpackage

// File: rtl/ppi_sync_core_if.sv
// CPU-side register bus of the PPI core: address, one-cycle strobes, data.
interface ppi_sync_core_if #(parameter int DW = 8);
  logic [1:0]    A;
  logic          RD;
  logic          WR;
  logic [DW-1:0] DIN;
  logic [DW-1:0] DOUT;

  modport master (output A, RD, WR, DIN, input DOUT);
  modport slave  (input A, RD, WR, DIN, output DOUT);
endinterface

// File: rtl/ppi_hs_port.sv
// One handshake-capable port (A or B): latches, strobe/ack edge detect, IBF/OBF.
// INTE/INTR logic exists only when PPI_INTR_EN is defined.
module ppi_hs_port
  import ppi_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          srst,
  input  ppi_mode_t     mode,
  input  logic          dirIn,
  input  logic          modeSet,
  input  logic          wrStb,
  input  logic          rdStb,
  input  logic [DW-1:0] wrData,
  input  logic [DW-1:0] pinIn,
  input  logic          stbN,
  input  logic          ackN,
  input  logic          inteWe,
  input  logic          inteVal,
  output logic [DW-1:0] outLatch,
  output logic [DW-1:0] rdData,
  output logic [DW-1:0] oe,
  output logic          ibf,
  output logic          obfN,
  output logic          intr
);

  logic          stbQ, ackQ;
  logic          ibfReg, obfNReg;
  logic [DW-1:0] inLatchReg, outLatchReg;
  logic          m1In, m1Out, stbFall, ackFall;

  assign m1In    = (mode == MODE1) && dirIn;
  assign m1Out   = (mode == MODE1) && !dirIn;
  assign stbFall = stbQ & ~stbN;
  assign ackFall = ackQ & ~ackN;

  always_ff @(posedge clk) begin
    if (srst) begin
      stbQ        <= 1'b1;
      ackQ        <= 1'b1;
      inLatchReg  <= '0;
      outLatchReg <= '0;
      ibfReg      <= 1'b0;
      obfNReg     <= 1'b1;
    end else begin
      stbQ <= stbN;
      ackQ <= ackN;
      if (modeSet) begin
        outLatchReg <= '0;
        ibfReg      <= 1'b0;
        obfNReg     <= 1'b1;
      end else begin
        if (wrStb) outLatchReg <= wrData;
        // A new strobe wins over a read in the same cycle: the read sees the old latch.
        if (m1In && stbFall) begin
          inLatchReg <= pinIn;
          ibfReg     <= 1'b1;
        end else if (m1In && rdStb) begin
          ibfReg <= 1'b0;
        end
        if (m1Out && wrStb) obfNReg <= 1'b0;
        else if (m1Out && ackFall) obfNReg <= 1'b1;
      end
    end
  end

`ifdef PPI_INTR_EN
  logic inteReg, intrReg, stbRise, ackRise;

  assign stbRise = ~stbQ & stbN;
  assign ackRise = ~ackQ & ackN;

  always_ff @(posedge clk) begin
    if (srst || modeSet) begin
      inteReg <= 1'b0;
      intrReg <= 1'b0;
    end else begin
      if (inteWe) inteReg <= inteVal;
      if (m1In) begin
        if (rdStb) intrReg <= 1'b0;
        else if (stbRise && ibfReg && inteReg) intrReg <= 1'b1;
      end else if (m1Out) begin
        if (wrStb) intrReg <= 1'b0;
        else if (ackRise && inteReg) intrReg <= 1'b1;
      end
    end
  end

  assign intr = intrReg;
`else
  logic unusedInte;
  assign unusedInte = &{1'b0, inteWe, inteVal};
  assign intr       = 1'b0;
`endif

  assign outLatch = outLatchReg;
  assign rdData   = dirIn ? ((mode == MODE1) ? inLatchReg : pinIn) : outLatchReg;
  assign oe       = dirIn ? '0 : '1;
  assign ibf      = ibfReg;
  assign obfN     = obfNReg;

endmodule

// File: rtl/ppi_sync_core.sv
// Synchronous PPI: control word, port C with bit set/reset, read mux and decode;
// ports A/B are ppi_hs_port instances. Optional interrupts: define PPI_INTR_EN.
module ppi_sync_core
  import ppi_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic            CLK,
  input  logic            RESET,
  ppi_sync_core_if.slave  bus,
  input  logic [DW-1:0]   PA_IN,
  input  logic [DW-1:0]   PB_IN,
  input  logic [DW-1:0]   PC_IN,
  output logic [DW-1:0]   PA_OUT,
  output logic [DW-1:0]   PB_OUT,
  output logic [DW-1:0]   PC_OUT,
  output logic [DW-1:0]   PA_OE,
  output logic [DW-1:0]   PB_OE,
  output logic [DW-1:0]   PC_OE,
  input  logic            STB_A_N,
  input  logic            STB_B_N,
  input  logic            ACK_A_N,
  input  logic            ACK_B_N,
  output logic            IBF_A,
  output logic            IBF_B,
  output logic            OBF_A_N,
  output logic            OBF_B_N,
  output logic            INTR_A,
  output logic            INTR_B
);

  localparam int         IW     = $clog2(DW);
  localparam int         HW     = DW / 2;
  localparam logic [6:0] DW_LIM = 7'(DW);

  logic [CW-1:0] ctrlReg;
  logic [DW-1:0] pcOutReg, pcRead, doutReg, doutNext;
  logic          rdEff, wrCtrl, modeSet, bsr, bsrHit;
  logic [5:0]    bsrIdx;

  // RD and WR together is treated as a write only.
  assign rdEff   = bus.RD & ~bus.WR;
  assign wrCtrl  = bus.WR && (bus.A == ADDR_CTRL);
  assign modeSet = wrCtrl && bus.DIN[CW_MODE_SET];
  assign bsr     = wrCtrl && !bus.DIN[CW_MODE_SET];
  assign bsrIdx  = bus.DIN[6:1];
  assign bsrHit  = bsr && ({1'b0, bsrIdx} < DW_LIM);

  ppi_mode_t     portMode [2];
  logic [DW-1:0] portPin [2];
  logic [DW-1:0] portOut [2];
  logic [DW-1:0] portRdData [2];
  logic [DW-1:0] portOe [2];
  logic [1:0]    portDirIn, portWr, portRd, portStbN, portAckN, portInteWe;
  logic [1:0]    portIbf, portObfN, portIntr;

  assign portMode[0] = modeOfA(ctrlReg);
  assign portMode[1] = modeOfB(ctrlReg);
  assign portDirIn   = {ctrlReg[CW_DIR_B], ctrlReg[CW_DIR_A]};
  assign portPin[0]  = PA_IN;
  assign portPin[1]  = PB_IN;
  assign portStbN    = {STB_B_N, STB_A_N};
  assign portAckN    = {ACK_B_N, ACK_A_N};

  // Port index doubles as its bus address and its INTE bit-set/reset index.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gPort
      assign portWr[gi]     = bus.WR && (bus.A == 2'(gi));
      assign portRd[gi]     = rdEff && (bus.A == 2'(gi));
      assign portInteWe[gi] = bsr && (bsrIdx == 6'(gi));

      ppi_hs_port #(.DW(DW)) uPort (
        .clk      (CLK),
        .srst     (RESET),
        .mode     (portMode[gi]),
        .dirIn    (portDirIn[gi]),
        .modeSet  (modeSet),
        .wrStb    (portWr[gi]),
        .rdStb    (portRd[gi]),
        .wrData   (bus.DIN),
        .pinIn    (portPin[gi]),
        .stbN     (portStbN[gi]),
        .ackN     (portAckN[gi]),
        .inteWe   (portInteWe[gi]),
        .inteVal  (bus.DIN[0]),
        .outLatch (portOut[gi]),
        .rdData   (portRdData[gi]),
        .oe       (portOe[gi]),
        .ibf      (portIbf[gi]),
        .obfN     (portObfN[gi]),
        .intr     (portIntr[gi])
      );
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RESET) ctrlReg <= CTRL_RESET;
    else if (modeSet) ctrlReg <= bus.DIN[CW-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RESET || modeSet) pcOutReg <= '0;
    else if (bus.WR && (bus.A == ADDR_PC)) pcOutReg <= bus.DIN;
    else if (bsrHit) pcOutReg[bsrIdx[IW-1:0]] <= bus.DIN[0];
  end

  assign pcRead = {ctrlReg[CW_DIR_PCU] ? PC_IN[DW-1:HW] : pcOutReg[DW-1:HW],
                   ctrlReg[CW_DIR_PCL] ? PC_IN[HW-1:0]  : pcOutReg[HW-1:0]};

  always_comb begin
    doutNext = doutReg;
    if (rdEff) begin
      case (bus.A)
        ADDR_PA: doutNext = portRdData[0];
        ADDR_PB: doutNext = portRdData[1];
        ADDR_PC: doutNext = pcRead;
        default: begin
          doutNext          = '0;
          doutNext[CW-1:0]  = ctrlReg;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) doutReg <= '0;
    else doutReg <= doutNext;
  end

  assign bus.DOUT = doutReg;
  assign PA_OUT   = portOut[0];
  assign PB_OUT   = portOut[1];
  assign PC_OUT   = pcOutReg;
  assign PA_OE    = portOe[0];
  assign PB_OE    = portOe[1];
  assign PC_OE    = {{HW{~ctrlReg[CW_DIR_PCU]}}, {HW{~ctrlReg[CW_DIR_PCL]}}};
  assign IBF_A    = portIbf[0];
  assign IBF_B    = portIbf[1];
  assign OBF_A_N  = portObfN[0];
  assign OBF_B_N  = portObfN[1];
  assign INTR_A   = portIntr[0];
  assign INTR_B   = portIntr[1];

endmodule

// File: tb/tb_ppi_sync_core.sv
// Directed bench for ppi_sync_core (DW=8): mode 0, mode 1 in/out, BSR, collisions, reset abort.
module tb_ppi_sync_core;

  localparam int DW = 8;
`ifdef PPI_INTR_EN
  localparam logic INTR_EXP = 1'b1;
`else
  localparam logic INTR_EXP = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET;
  logic [DW-1:0] PA_IN, PB_IN, PC_IN;
  logic [DW-1:0] PA_OUT, PB_OUT, PC_OUT, PA_OE, PB_OE, PC_OE;
  logic STB_A_N, STB_B_N, ACK_A_N, ACK_B_N;
  logic IBF_A, IBF_B, OBF_A_N, OBF_B_N, INTR_A, INTR_B;
  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  ppi_sync_core_if #(.DW(DW)) bus ();

  ppi_sync_core #(.DW(DW), .CW(8)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus),
    .PA_IN(PA_IN), .PB_IN(PB_IN), .PC_IN(PC_IN),
    .PA_OUT(PA_OUT), .PB_OUT(PB_OUT), .PC_OUT(PC_OUT),
    .PA_OE(PA_OE), .PB_OE(PB_OE), .PC_OE(PC_OE),
    .STB_A_N(STB_A_N), .STB_B_N(STB_B_N), .ACK_A_N(ACK_A_N), .ACK_B_N(ACK_B_N),
    .IBF_A(IBF_A), .IBF_B(IBF_B), .OBF_A_N(OBF_A_N), .OBF_B_N(OBF_B_N),
    .INTR_A(INTR_A), .INTR_B(INTR_B)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wrBus(input logic [1:0] a, input logic [7:0] d);
    bus.A = a; bus.DIN = d; bus.WR = 1'b1;
    tick();
    bus.WR = 1'b0;
    $display("WR A=%0d DIN=%h", a, d);
  endtask

  task automatic rdBus(input logic [1:0] a);
    bus.A = a; bus.RD = 1'b1;
    tick();
    bus.RD = 1'b0;
    $display("RD A=%0d DOUT=%h", a, bus.DOUT);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick(); tick();
    RESET = 1'b0;
    checks++; if ({PA_OE, PB_OE, PC_OE} !== 24'h0) begin failures++; $display("FAIL rst_oe got=%h exp=000000", {PA_OE, PB_OE, PC_OE}); end
    checks++; if ({PA_OUT, PB_OUT, PC_OUT} !== 24'h0) begin failures++; $display("FAIL rst_out got=%h exp=000000", {PA_OUT, PB_OUT, PC_OUT}); end
    checks++; if ({OBF_A_N, OBF_B_N, IBF_A, IBF_B, INTR_A, INTR_B} !== 6'b110000) begin failures++; $display("FAIL rst_hs got=%b exp=110000", {OBF_A_N, OBF_B_N, IBF_A, IBF_B, INTR_A, INTR_B}); end
    checks++; if (bus.DOUT !== 8'h00) begin failures++; $display("FAIL rst_dout got=%h exp=00", bus.DOUT); end
    rdBus(2'd3);
    checks++; if (bus.DOUT !== 8'h9B) begin failures++; $display("FAIL rst_ctrl_read got=%h exp=9b", bus.DOUT); end
    tick();
    checks++; if (bus.DOUT !== 8'h9B) begin failures++; $display("FAIL dout_hold got=%h exp=9b", bus.DOUT); end
  endtask

  task automatic test_mode0_out();
    wrBus(2'd3, 8'h80);
    wrBus(2'd0, 8'h5A);
    checks++; if (PA_OE !== 8'hFF) begin failures++; $display("FAIL m0_pa_oe got=%h exp=ff", PA_OE); end
    checks++; if (PA_OUT !== 8'h5A) begin failures++; $display("FAIL m0_pa_out got=%h exp=5a", PA_OUT); end
    rdBus(2'd0);
    checks++; if (bus.DOUT !== 8'h5A) begin failures++; $display("FAIL m0_pa_read got=%h exp=5a", bus.DOUT); end
    bus.A = 2'd1; bus.DIN = 8'h42; bus.RD = 1'b1; bus.WR = 1'b1;
    tick();
    bus.RD = 1'b0; bus.WR = 1'b0;
    $display("RD+WR A=1 DIN=42 DOUT=%h PB_OUT=%h", bus.DOUT, PB_OUT);
    checks++; if (PB_OUT !== 8'h42) begin failures++; $display("FAIL rdwr_pb_out got=%h exp=42", PB_OUT); end
    checks++; if (bus.DOUT !== 8'h5A) begin failures++; $display("FAIL rdwr_dout got=%h exp=5a", bus.DOUT); end
    wrBus(2'd2, 8'h96);
    rdBus(2'd2);
    checks++; if (bus.DOUT !== 8'h96) begin failures++; $display("FAIL m0_pc_read got=%h exp=96", bus.DOUT); end
    checks++; if (PC_OE !== 8'hFF) begin failures++; $display("FAIL m0_pc_oe got=%h exp=ff", PC_OE); end
    STB_A_N = 1'b0; tick(); STB_A_N = 1'b1; tick();
    checks++; if ({IBF_A, OBF_A_N} !== 2'b01) begin failures++; $display("FAIL m0_stb_ignored got=%b exp=01", {IBF_A, OBF_A_N}); end
  endtask

  task automatic test_mode0_in();
    wrBus(2'd3, 8'h9B);
    checks++; if ({PA_OUT, PB_OUT, PC_OUT} !== 24'h0) begin failures++; $display("FAIL modeset_clear got=%h exp=000000", {PA_OUT, PB_OUT, PC_OUT}); end
    PA_IN = 8'hA5;
    rdBus(2'd0);
    checks++; if (bus.DOUT !== 8'hA5) begin failures++; $display("FAIL m0_pin_read got=%h exp=a5", bus.DOUT); end
    wrBus(2'd0, 8'h77);
    checks++; if ({PA_OUT, PA_OE} !== 16'h7700) begin failures++; $display("FAIL m0_in_latch got=%h exp=7700", {PA_OUT, PA_OE}); end
    wrBus(2'd3, 8'h88);
    wrBus(2'd2, 8'h3C);
    PC_IN = 8'hA5;
    rdBus(2'd2);
    checks++; if (bus.DOUT !== 8'hAC) begin failures++; $display("FAIL pc_mixed_read got=%h exp=ac", bus.DOUT); end
    checks++; if (PC_OE !== 8'h0F) begin failures++; $display("FAIL pc_mixed_oe got=%h exp=0f", PC_OE); end
  endtask

  task automatic test_mode1_in();
    wrBus(2'd3, 8'hB0);
    wrBus(2'd3, 8'h01);
    checks++; if ({PC_OUT, PA_OE} !== 16'h0100) begin failures++; $display("FAIL m1in_setup got=%h exp=0100", {PC_OUT, PA_OE}); end
    PA_IN = 8'h3C; STB_A_N = 1'b0;
    tick();
    PA_IN = 8'h11;
    checks++; if ({IBF_A, INTR_A} !== 2'b10) begin failures++; $display("FAIL m1in_stb_fall got=%b exp=10", {IBF_A, INTR_A}); end
    tick();
    STB_A_N = 1'b1;
    tick();
    checks++; if ({IBF_A, INTR_A} !== {1'b1, INTR_EXP}) begin failures++; $display("FAIL m1in_stb_rise got=%b exp=%b", {IBF_A, INTR_A}, {1'b1, INTR_EXP}); end
    rdBus(2'd0);
    checks++; if (bus.DOUT !== 8'h3C) begin failures++; $display("FAIL m1in_read got=%h exp=3c", bus.DOUT); end
    checks++; if ({IBF_A, INTR_A, OBF_A_N} !== 3'b001) begin failures++; $display("FAIL m1in_rd_clear got=%b exp=001", {IBF_A, INTR_A, OBF_A_N}); end
  endtask

  task automatic test_mode1_out();
    wrBus(2'd3, 8'h84);
    wrBus(2'd3, 8'h03);
    checks++; if ({PC_OUT, 7'h0, OBF_B_N} !== 16'h0201) begin failures++; $display("FAIL m1out_setup got=%h exp=0201", {PC_OUT, 7'h0, OBF_B_N}); end
    wrBus(2'd1, 8'hC3);
    checks++; if ({PB_OUT, PB_OE} !== 16'hC3FF) begin failures++; $display("FAIL m1out_wr got=%h exp=c3ff", {PB_OUT, PB_OE}); end
    checks++; if (OBF_B_N !== 1'b0) begin failures++; $display("FAIL m1out_obf_set got=%b exp=0", OBF_B_N); end
    ACK_B_N = 1'b0;
    tick();
    checks++; if ({OBF_B_N, INTR_B} !== 2'b10) begin failures++; $display("FAIL m1out_ack_fall got=%b exp=10", {OBF_B_N, INTR_B}); end
    ACK_B_N = 1'b1;
    tick();
    checks++; if (INTR_B !== INTR_EXP) begin failures++; $display("FAIL m1out_ack_rise got=%b exp=%b", INTR_B, INTR_EXP); end
    wrBus(2'd1, 8'h3C);
    checks++; if ({OBF_B_N, INTR_B} !== 2'b00) begin failures++; $display("FAIL m1out_wr_clear got=%b exp=00", {OBF_B_N, INTR_B}); end
    ACK_B_N = 1'b0;
    wrBus(2'd1, 8'h99);
    checks++; if ({PB_OUT, 7'h0, OBF_B_N} !== 16'h9900) begin failures++; $display("FAIL m1out_wr_ack got=%h exp=9900", {PB_OUT, 7'h0, OBF_B_N}); end
    ACK_B_N = 1'b1;
    tick();
    checks++; if ({OBF_B_N, INTR_B} !== {1'b0, INTR_EXP}) begin failures++; $display("FAIL m1out_after_coll got=%b exp=%b", {OBF_B_N, INTR_B}, {1'b0, INTR_EXP}); end
  endtask

  task automatic test_bsr();
    wrBus(2'd3, 8'h80);
    wrBus(2'd3, 8'h0F);
    checks++; if (PC_OUT !== 8'h80) begin failures++; $display("FAIL bsr_set7 got=%h exp=80", PC_OUT); end
    wrBus(2'd3, 8'h0E);
    checks++; if (PC_OUT !== 8'h00) begin failures++; $display("FAIL bsr_clr7 got=%h exp=00", PC_OUT); end
    wrBus(2'd3, 8'h0F);
    wrBus(2'd3, 8'h11);
    checks++; if (PC_OUT !== 8'h80) begin failures++; $display("FAIL bsr_idx_oob got=%h exp=80", PC_OUT); end
    rdBus(2'd3);
    checks++; if (bus.DOUT !== 8'h80) begin failures++; $display("FAIL bsr_ctrl_kept got=%h exp=80", bus.DOUT); end
  endtask

  task automatic test_stb_rd_collide();
    wrBus(2'd3, 8'hB0);
    PA_IN = 8'h12; STB_A_N = 1'b0;
    tick();
    STB_A_N = 1'b1;
    tick();
    checks++; if (IBF_A !== 1'b1) begin failures++; $display("FAIL coll_first_ibf got=%b exp=1", IBF_A); end
    PA_IN = 8'h34; STB_A_N = 1'b0;
    rdBus(2'd0);
    checks++; if ({bus.DOUT, 7'h0, IBF_A} !== 16'h1201) begin failures++; $display("FAIL coll_rd got=%h exp=1201", {bus.DOUT, 7'h0, IBF_A}); end
    STB_A_N = 1'b1;
    tick();
    rdBus(2'd0);
    checks++; if ({bus.DOUT, 7'h0, IBF_A} !== 16'h3400) begin failures++; $display("FAIL coll_new_data got=%h exp=3400", {bus.DOUT, 7'h0, IBF_A}); end
  endtask

  task automatic test_reset_abort();
    wrBus(2'd0, 8'h6B);
    PA_IN = 8'h55; STB_A_N = 1'b0;
    tick();
    STB_A_N = 1'b1;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    checks++; if ({IBF_A, OBF_A_N, INTR_A} !== 3'b010) begin failures++; $display("FAIL abort_hs got=%b exp=010", {IBF_A, OBF_A_N, INTR_A}); end
    checks++; if ({PA_OUT, PA_OE} !== 16'h0000) begin failures++; $display("FAIL abort_latch got=%h exp=0000", {PA_OUT, PA_OE}); end
    rdBus(2'd3);
    checks++; if (bus.DOUT !== 8'h9B) begin failures++; $display("FAIL abort_ctrl got=%h exp=9b", bus.DOUT); end
  endtask

  initial begin
    RESET = 1'b1;
    bus.A = 2'd0; bus.RD = 1'b0; bus.WR = 1'b0; bus.DIN = '0;
    PA_IN = '0; PB_IN = '0; PC_IN = '0;
    STB_A_N = 1'b1; STB_B_N = 1'b1; ACK_A_N = 1'b1; ACK_B_N = 1'b1;
    test_reset();
    test_mode0_out();
    test_mode0_in();
    test_mode1_in();
    test_mode1_out();
    test_bsr();
    test_stb_rd_collide();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
